// File: rtl/bdtu.sv
// Block data transfer unit: sequences LDM/STM one register per cycle, drives the
// data memory port and the two write-back ports used by forwarding.
module bdtu #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_load,
  input  logic            pre,
  input  logic            up,
  input  logic            wb,
  input  logic [3:0]      base_reg,
  input  logic [DW-1:0]   base_val,
  input  logic [NREG-1:0] reg_list,
  output logic [3:0]      rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic [DW-1:0]   mem_addr,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [3:0]      bdtu_wd1,
  output logic            bdtu_we1,
  output logic [DW-1:0]   bdtu_wdata1,
  output logic [3:0]      bdtu_wd2,
  output logic            bdtu_we2,
  output logic [DW-1:0]   bdtu_wdata2,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(NREG + 1);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t          state;
  logic [NREG-1:0] remain;
  logic [NREG-1:0] list_q;
  logic [3:0]      cur;
  logic [3:0]      base_q;
  logic            load_q;
  logic            wb_q;
  logic [DW-1:0]   final_base;

  logic [CW-1:0]   n;
  logic [DW-1:0]   span;
  logic [DW-1:0]   first_addr;
  logic [3:0]      first_reg;
  logic [3:0]      nxt;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c += CW'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest(input logic [NREG-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Decrementing modes still walk upward: the block starts at the lowest address.
  always_comb begin
    n         = popcount(reg_list);
    span      = DW'(n) << 2;
    first_reg = lowest(reg_list);
    nxt       = lowest(remain);
    case ({pre, up})
      2'b01:   first_addr = base_val;
      2'b11:   first_addr = base_val + DW'(4);
      2'b00:   first_addr = base_val - span + DW'(4);
      default: first_addr = base_val - span;
    endcase
  end

  // Store data and load data pass straight through, gated so idle outputs stay 0.
  assign mem_wdata   = (state == XFER && !load_q) ? rd_data : '0;
  assign bdtu_wdata1 = bdtu_we1 ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_q      <= 1'b0;
      wb_q        <= 1'b0;
      rd_addr     <= '0;
      mem_addr    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      bdtu_wd1    <= '0;
      bdtu_we1    <= 1'b0;
      bdtu_wd2    <= '0;
      bdtu_we2    <= 1'b0;
      bdtu_wdata2 <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      bdtu_we1 <= 1'b0;
      bdtu_we2 <= 1'b0;
      case (state)
        IDLE: begin
          busy        <= 1'b0;
          mem_en      <= 1'b0;
          mem_we      <= 1'b0;
          mem_addr    <= '0;
          rd_addr     <= '0;
          bdtu_wd1    <= '0;
          bdtu_wd2    <= '0;
          bdtu_wdata2 <= '0;
          if (start) begin
            load_q     <= is_load;
            wb_q       <= wb;
            base_q     <= base_reg;
            list_q     <= reg_list;
            final_base <= up ? base_val + span : base_val - span;
            busy       <= 1'b1;
            if (n == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= XFER;
              mem_en   <= 1'b1;
              mem_we   <= !is_load;
              mem_addr <= first_addr;
              rd_addr  <= is_load ? 4'd0 : first_reg;
              cur      <= first_reg;
              remain   <= reg_list & ~(NREG'(1) << first_reg);
            end
          end
        end
        XFER: begin
          // Load data for the register served last cycle returns now.
          bdtu_we1 <= load_q;
          bdtu_wd1 <= load_q ? cur : 4'd0;
          if (remain == '0) begin
            state       <= FIN;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            rd_addr     <= '0;
            done        <= 1'b1;
            bdtu_we2    <= wb_q && !(load_q && list_q[base_q]);
            bdtu_wd2    <= base_q;
            bdtu_wdata2 <= final_base;
          end else begin
            mem_addr <= mem_addr + DW'(4);
            cur      <= nxt;
            rd_addr  <= load_q ? 4'd0 : nxt;
            remain   <= remain & ~(NREG'(1) << nxt);
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          bdtu_wd1    <= '0;
          bdtu_wd2    <= '0;
          bdtu_wdata2 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bdtu.sv
// Scoreboard bench for bdtu: a reference model queues the expected memory
// accesses and write-backs per operation; a negedge monitor pops and compares.
module tb_bdtu;

  logic        clk = 1'b0;
  logic        rst, start, is_load, pre, up, wb;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] mem_addr;
  logic        mem_en, mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  bdtu_wd1, bdtu_wd2;
  logic        bdtu_we1, bdtu_we2;
  logic [31:0] bdtu_wdata1, bdtu_wdata2;
  logic        busy, done;

  bdtu #(.DW(32), .NREG(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre(pre), .up(up),
    .wb(wb), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .rd_addr(rd_addr), .rd_data(rd_data), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bdtu_wd1(bdtu_wd1), .bdtu_we1(bdtu_we1), .bdtu_wdata1(bdtu_wdata1),
    .bdtu_wd2(bdtu_wd2), .bdtu_we2(bdtu_we2), .bdtu_wdata2(bdtu_wdata2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  r;
  } ev_t;

  ev_t         mq[$];
  ev_t         p1q[$];
  ev_t         p2q[$];
  int          dq[$];
  ev_t         mev;
  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          cnt = 0;
  int          t0 = 0;
  int          fin = 0;
  int          rel;
  logic        tracking = 1'b0;
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  assign rd_data = rf[rd_addr];

  always @(posedge clk) begin
    cnt       <= cnt + 1;
    mem_rdata <= (mem_en && !mem_we) ? memrd(mem_addr) : 32'hBAD0_BAD0;
  end

  task automatic model(input logic ld, input logic pr, input logic u, input logic w,
                       input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst);
    int n = 0;
    int k = 1;
    logic [31:0] a;
    ev_t e;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    if (u) a = pr ? bv + 32'd4 : bv;
    else   a = pr ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        e.cyc = k; e.addr = a; e.we = !ld; e.data = ld ? 32'd0 : rf[i]; e.r = 4'(i);
        mq.push_back(e);
        if (ld) begin
          e.cyc = k + 1; e.data = memrd(a);
          p1q.push_back(e);
        end
        a = a + 32'd4;
        k++;
      end
    end
    fin = n + 1;
    if (w && n > 0 && !(ld && lst[br])) begin
      e.cyc = fin; e.r = br; e.addr = 0; e.we = 0;
      e.data = u ? bv + 32'(4 * n) : bv - 32'(4 * n);
      p2q.push_back(e);
    end
    dq.push_back(fin);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cnt - t0;
      chk("busy", 32'(busy), 32'(tracking && rel >= 1 && rel <= fin));
      if (mem_en) begin
        if (mq.size() == 0) chk("mem_unexp", 32'(mem_en), 32'd0);
        else begin
          mev = mq.pop_front();
          chk("mem_cyc", 32'(rel), 32'(mev.cyc));
          chk("mem_addr", mem_addr, mev.addr);
          chk("mem_we", 32'(mem_we), 32'(mev.we));
          if (mev.we) begin
            chk("rd_addr", 32'(rd_addr), 32'(mev.r));
            chk("mem_wdata", mem_wdata, mev.data);
          end
        end
      end
      if (bdtu_we1) begin
        if (p1q.size() == 0) chk("we1_unexp", 32'(bdtu_we1), 32'd0);
        else begin
          mev = p1q.pop_front();
          chk("we1_cyc", 32'(rel), 32'(mev.cyc));
          chk("wd1", 32'(bdtu_wd1), 32'(mev.r));
          chk("wdata1", bdtu_wdata1, mev.data);
        end
      end
      if (bdtu_we2) begin
        if (p2q.size() == 0) chk("we2_unexp", 32'(bdtu_we2), 32'd0);
        else begin
          mev = p2q.pop_front();
          chk("we2_cyc", 32'(rel), 32'(mev.cyc));
          chk("wd2", 32'(bdtu_wd2), 32'(mev.r));
          chk("wdata2", bdtu_wdata2, mev.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexp", 32'(done), 32'd0);
        else chk("done_cyc", 32'(rel), 32'(dq.pop_front()));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_we1"}, 32'(bdtu_we1), 32'd0);
    chk({tag, "_wdata1"}, bdtu_wdata1, 32'd0);
    chk({tag, "_we2"}, 32'(bdtu_we2), 32'd0);
    chk({tag, "_wdata2"}, bdtu_wdata2, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_op(input logic ld, input logic pr, input logic u, input logic w,
                        input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst,
                        input int abort_at, input int restart_at);
    int last;
    @(posedge clk); #1;
    is_load = ld; pre = pr; up = u; wb = w;
    base_reg = br; base_val = bv; reg_list = lst; start = 1'b1;
    model(ld, pr, u, w, br, bv, lst);
    t0 = cnt;
    tracking = 1'b1;
    last = fin + 2;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == restart_at) begin
        is_load = ~ld; base_val = 32'hDEAD_0000; reg_list = 16'hFFFF; wb = 1'b1;
      end
      if (k == abort_at) rst = 1'b1;
      if (abort_at > 0 && k == abort_at + 1) begin
        rst = 1'b0;
        mq.delete(); p1q.delete(); p2q.delete(); dq.delete();
        tracking = 1'b0;
        check_idle_outputs("abort");
      end
    end
    start = 1'b0;
    tracking = 1'b0;
    chk("mem_left", 32'(mq.size()), 32'd0);
    chk("p1_left", 32'(p1q.size()), 32'd0);
    chk("p2_left", 32'(p2q.size()), 32'd0);
    chk("done_left", 32'(dq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wb = 1'b0;
    base_reg = '0; base_val = '0; reg_list = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[4] = 32'd1; rf[5] = 32'd2; rf[6] = 32'd3; rf[7] = 32'd4; rf[9] = 32'h300;
    mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // LDMIA R0!,{R1,R2,R4}
    run_op(1, 0, 1, 1, 4'd0, 32'h100, 16'h0016, 0, 0);
    // STMDB R13!,{R4-R7}
    run_op(0, 1, 0, 1, 4'd13, 32'h1000, 16'h00F0, 0, 0);
    // LDMIB R0!,{R0,R3}: base in list, no port-2 write
    run_op(1, 1, 1, 1, 4'd0, 32'h200, 16'h0009, 0, 0);
    // Empty list with write-back requested
    run_op(1, 0, 1, 1, 4'd2, 32'h400, 16'h0000, 0, 0);
    // LDMDA R5!,{R1,R2} from base 0: address wrap
    run_op(1, 0, 0, 1, 4'd5, 32'h0, 16'h0006, 0, 0);
    // Reset during cycle 2 of a 4-register LDM
    run_op(1, 0, 1, 1, 4'd8, 32'h500, 16'h001E, 2, 0);
    // STMIA R9!,{R9,R10}: stores the unmodified base
    run_op(0, 0, 1, 1, 4'd9, 32'h300, 16'h0600, 0, 0);
    // LDMIA R1,{R3,R15} without write-back
    run_op(1, 0, 1, 0, 4'd1, 32'h800, 16'h8008, 0, 0);
    // STMIA R2!,{R0,R1,R3} with a second start pulsed while busy
    run_op(0, 0, 1, 1, 4'd2, 32'h600, 16'h000B, 0, 2);
    // Random operations
    for (int t = 0; t < 6; t++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
             16'($urandom()), 0, 0);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bdtu.md
Name: bdtu

Overview:
- Block Data Transfer Unit: sequences LDM/STM multi-register transfers, one register per cycle.
- Stalls the pipeline while active via `busy`.
- Drives the memory port.
- Produces the two register write-back ports the forwarding logic consumes:
  - port 1: loaded data register;
  - port 2: base register write-back.
- Sits beside the MEM stage and shares the data memory and the register-file read port.

Parameters:
- DW, 32, data/address width.
- NREG, 16, register count; fixes reg_list width and 4-bit register addresses.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  accept new LDM/STM (ignored while busy)
- is_load  input  1  1=LDM, 0=STM
- pre  input  1  P bit: 1=before, 0=after
- up  input  1  U bit: 1=increment, 0=decrement
- wb  input  1  W bit: base write-back requested
- base_reg  input  4  base register number
- base_val  input  DW  base register value at start
- reg_list  input  NREG  register list bitmap
- rd_addr  output  4  register-file read address (store data)
- rd_data  input  DW  combinational register-file read data
- mem_addr  output  DW  word address to data memory
- mem_en  output  1  memory access valid
- mem_we  output  1  memory write strobe
- mem_wdata  output  DW  store data
- mem_rdata  input  DW  load data, valid the cycle after mem_en
- bdtu_wd1  output  4  port 1 destination register
- bdtu_we1  output  1  port 1 write enable
- bdtu_wdata1  output  DW  port 1 data
- bdtu_wd2  output  4  port 2 destination register (base)
- bdtu_we2  output  1  port 2 write enable
- bdtu_wdata2  output  DW  port 2 data
- busy  output  1  stall request
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; every output 0 (addresses/data 0, all enables 0, busy 0, done 0).
- Reset mid-operation: abort immediately, return to IDLE. No further mem_en, we1 or we2.
- Start (cycle 0): in IDLE with start=1, latch all inputs. Compute:
  - N = popcount(reg_list), 0..16;
  - start address:
    - IA: base;
    - IB: base+4;
    - DA: base-4N+4;
    - DB: base-4N.
  - All arithmetic is DW-bit modulo 2^DW; wrap-around is permitted.
- start while busy=1 is ignored.
- States:
  - IDLE -> XFER if N>0.
  - IDLE -> FIN if N==0.
  - XFER -> FIN after the N-th transfer.
  - FIN -> IDLE.
- XFER, cycles 1..N: one register per cycle, lowest-numbered register first, at the lowest address. Address increments by 4 each cycle regardless of U. The next register comes from a priority encoder on the remaining list, with the served bit cleared.
  - Store: mem_en=1, mem_we=1, rd_addr=current register, mem_wdata=rd_data.
  - Load: mem_en=1, mem_we=0. In the following cycle: bdtu_we1=1, bdtu_wd1=previous register, bdtu_wdata1=mem_rdata. Load writes therefore occur in cycles 2..N+1.
- FIN, cycle N+1 (cycle 1 if N==0):
  - Last load write on port 1 if is_load and N>0.
  - Port 2: we2=1 when wb=1 and N>0; wd2=base_reg; wdata2 = up ? base+4N : base-4N.
  - Port 2 is suppressed when is_load=1 and base_reg is in reg_list: the loaded value wins.
  - done=1 for exactly this cycle.
- busy: 1 from cycle 1 through FIN inclusive; 0 in IDLE.
- Store with base in list: stores the unmodified base value, since the register file is not yet written.
- R15 in a load list: written through port 1 like any other register (wd1=15); flush handling is external.
- Port 1 and port 2 may both be active in FIN; they never target the same register, because the suppression rule above prevents it.
- Empty list (N==0): no memory access, no register write, done at cycle 1.

Test Plan:
- LDMIA R0!,{R1,R2,R4}, base 0x100, memory returns 0xA,0xB,0xC:
  - mem_addr 0x100/0x104/0x108 in cycles 1-3;
  - we1 (R1=0xA, R2=0xB, R4=0xC) in cycles 2-4;
  - we2 R0=0x10C in cycle 4;
  - done in cycle 4; busy cycles 1-4.
- STMDB R13!,{R4-R7}, SP=0x1000, R4..R7=1..4:
  - writes 1..4 at 0xFF0,0xFF4,0xFF8,0xFFC, rd_addr 4..7;
  - we2 R13=0xFF0 in cycle 5.
- LDMIB R0!,{R0,R3}, base 0x200:
  - addresses 0x204, 0x208;
  - R0 gets loaded data via port 1; we2 never asserted.
- reg_list=0, wb=1: no mem_en/we1/we2; done and busy high in cycle 1 only. Then LDMDA base 0x0,{R1,R2}: addresses 0xFFFFFFFC, 0x0 (wrap).
- Reset asserted in cycle 2 of a 4-register LDM: all outputs 0 from the next cycle; no we1/we2. A subsequent start is accepted normally.
- Second start pulsed while busy: ignored; the first transfer completes unchanged with a single done pulse.
